// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - shared types and default address map for the memory map controller
package mem_map_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Default map: instruction memory, ROM, RAM (bases and sizes in words)
    localparam logic [31:0] INS_BASE = 32'd0;
    localparam logic [31:0] INS_SIZE = 32'd1000;
    localparam logic [31:0] ROM_BASE = 32'd1000;
    localparam logic [31:0] ROM_SIZE = 32'd30000;
    localparam logic [31:0] RAM_BASE = 32'd31000;
    localparam logic [31:0] RAM_SIZE = 32'd30015;
    localparam logic [2:0]  DEFAULT_WRITABLE = 3'b100;

    function automatic int calc_lanes(input int v, input int s);
        return v / s;
    endfunction

endpackage

// File: rtl/mem_region_decode.sv
// rtl/mem_region_decode.sv - combinational window/protection decode for one access
module mem_region_decode
    import mem_map_pkg::*;
#(
    parameter int S           = 32,
    parameter int NUM_REGIONS = 3,
    parameter int IW          = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1,
    parameter logic [NUM_REGIONS*S-1:0] REGION_BASE     = {RAM_BASE, ROM_BASE, INS_BASE},
    parameter logic [NUM_REGIONS*S-1:0] REGION_SIZE     = {RAM_SIZE, ROM_SIZE, INS_SIZE},
    parameter logic [NUM_REGIONS-1:0]   REGION_WRITABLE = DEFAULT_WRITABLE
) (
    input  logic [S-1:0]  addr,
    input  logic [S:0]    nbeats,
    input  logic          we,
    output logic          hit,
    output logic [IW-1:0] region,
    output logic [S-1:0]  offset,
    output logic          err
);

    logic [S:0] last;
    logic [S:0] base;
    logic [S:0] lim;

    always_comb begin
        hit    = 1'b0;
        region = '0;
        offset = '0;
        base   = '0;
        lim    = '0;
        // One extra bit so an access running past 2^S is visible as last[S]
        last   = {1'b0, addr} + nbeats - 1'b1;
        // Descending scan lets the lowest hitting index win
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            base = {1'b0, REGION_BASE[i*S +: S]};
            lim  = base + {1'b0, REGION_SIZE[i*S +: S]};
            if (base <= {1'b0, addr} && last < lim) begin
                hit    = 1'b1;
                region = IW'(i);
                offset = addr - REGION_BASE[i*S +: S];
            end
        end
        err = !hit || last[S] || (we && !REGION_WRITABLE[region]);
    end

endmodule

// File: rtl/mem_map_ctrl.sv
// rtl/mem_map_ctrl.sv - handshaked address-map controller splitting vector accesses into word beats
module mem_map_ctrl
    import mem_map_pkg::*;
#(
    parameter int S           = 32,
    parameter int V           = 192,
    parameter int NUM_REGIONS = 3,
    parameter logic [NUM_REGIONS*S-1:0] REGION_BASE     = {RAM_BASE, ROM_BASE, INS_BASE},
    parameter logic [NUM_REGIONS*S-1:0] REGION_SIZE     = {RAM_SIZE, ROM_SIZE, INS_SIZE},
    parameter logic [NUM_REGIONS-1:0]   REGION_WRITABLE = DEFAULT_WRITABLE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic                     req_vec,
    input  logic [S-1:0]             req_addr,
    input  logic [V-1:0]             req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [V-1:0]             resp_rdata,
    output logic                     resp_err,
    output logic [NUM_REGIONS-1:0]   mem_sel,
    output logic                     mem_we,
    output logic [S-1:0]             mem_addr,
    output logic [S-1:0]             mem_wdata,
    input  logic [NUM_REGIONS*S-1:0] mem_rdata
);

    localparam int LANES = calc_lanes(V, S);
    localparam int IW    = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int CW    = $clog2(LANES + 1);

    if (V % S != 0) begin : g_bad_width
        $error("mem_map_ctrl: V must be a multiple of S");
    end

    state_t          state;
    logic [CW-1:0]   beat;
    logic [CW-1:0]   last_beat;
    logic            we_q;
    logic [IW-1:0]   region_q;
    logic [V-1:0]    wdata_q;

    logic            dec_hit;
    logic            dec_err;
    logic [IW-1:0]   dec_region;
    logic [S-1:0]    dec_offset;
    logic [S:0]      dec_nbeats;
    logic [S-1:0]    rd_slice;

    assign dec_nbeats = req_vec ? (S+1)'(LANES) : (S+1)'(1);
    assign req_ready  = (state == IDLE);
    assign rd_slice   = mem_rdata[region_q*S +: S];

    mem_region_decode #(
        .S               (S),
        .NUM_REGIONS     (NUM_REGIONS),
        .IW              (IW),
        .REGION_BASE     (REGION_BASE),
        .REGION_SIZE     (REGION_SIZE),
        .REGION_WRITABLE (REGION_WRITABLE)
    ) u_decode (
        .addr   (req_addr),
        .nbeats (dec_nbeats),
        .we     (req_we),
        .hit    (dec_hit),
        .region (dec_region),
        .offset (dec_offset),
        .err    (dec_err)
    );

    // mem_* are registered one beat ahead; read data trails the bus by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            beat       <= '0;
            last_beat  <= '0;
            we_q       <= 1'b0;
            region_q   <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_sel    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        resp_rdata <= '0;
                        if (!dec_hit || dec_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            beat      <= '0;
                            last_beat <= req_vec ? CW'(LANES - 1) : '0;
                            we_q      <= req_we;
                            region_q  <= dec_region;
                            wdata_q   <= req_wdata;
                            resp_err  <= 1'b0;
                            mem_sel   <= NUM_REGIONS'(1) << dec_region;
                            mem_we    <= req_we;
                            mem_addr  <= dec_offset;
                            mem_wdata <= req_wdata[S-1:0];
                        end
                    end
                end
                ISSUE: begin
                    if (!we_q && beat != '0) begin
                        resp_rdata[(beat - 1'b1)*S +: S] <= rd_slice;
                    end
                    if (beat == last_beat) begin
                        mem_sel   <= '0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        if (we_q) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        beat      <= beat + 1'b1;
                        mem_addr  <= mem_addr + 1'b1;
                        mem_wdata <= wdata_q[(beat + 1'b1)*S +: S];
                    end
                end
                DRAIN: begin
                    resp_rdata[beat*S +: S] <= rd_slice;
                    state      <= RESP;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_map_ctrl.sv
// tb/tb_mem_map_ctrl.sv - self-checking bench for mem_map_ctrl against a word-level reference model
module tb_mem_map_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_we = 1'b0;
    logic         req_vec = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [191:0] req_wdata = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [191:0] resp_rdata;
    logic         resp_err;
    logic [2:0]   mem_sel;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [95:0]  mem_rdata = '0;

    int checks = 0;
    int failures = 0;

    longint     base_tab [3] = '{0, 1000, 31000};
    longint     size_tab [3] = '{1000, 30000, 30015};
    logic [2:0] wr_tab = 3'b100;

    bit [31:0] dev_mem   [int];
    bit [31:0] model_mem [int];

    mem_map_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_vec    (req_vec),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_sel    (mem_sel),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic bit [31:0] pat(input int key);
        return key * 32'h9E3779B1;
    endfunction

    function automatic bit [31:0] dev_get(input int key);
        return dev_mem.exists(key) ? dev_mem[key] : pat(key);
    endfunction

    function automatic bit [31:0] model_get(input int key);
        return model_mem.exists(key) ? model_mem[key] : pat(key);
    endfunction

    // Backing arrays: synchronous read with one-cycle latency, write on strobe
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mem_sel[i]) begin
                mem_rdata[i*32 +: 32] <= dev_get(i*65536 + int'(mem_addr));
                if (mem_we) dev_mem[i*65536 + int'(mem_addr)] = mem_wdata;
            end
        end
    end

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the address-map rules, using wide integer arithmetic
    task automatic ref_decode(input bit vec, input bit we, input longint addr,
                              output bit err, output int rg, output longint off);
        longint last;
        last = addr + (vec ? 6 : 1) - 1;
        rg = -1;
        off = 0;
        for (int i = 0; i < 3; i++) begin
            if (rg < 0 && addr >= base_tab[i] && last < base_tab[i] + size_tab[i]) begin
                rg = i;
                off = addr - base_tab[i];
            end
        end
        err = (rg < 0) || (last >= 64'h1_0000_0000) || (we && rg >= 0 && !wr_tab[rg]);
    endtask

    // Caller is just after a negedge; returns just after a negedge with req_valid low
    task automatic do_txn(input bit we, input bit vec, input logic [31:0] addr,
                          input logic [191:0] wd, input int stall, input string tag);
        bit err; int rg; longint off; int nb; int lat; int cyc; int seen;
        logic [191:0] exp_rd;
        ref_decode(vec, we, longint'(addr), err, rg, off);
        nb = vec ? 6 : 1;
        lat = err ? 1 : (we ? nb + 1 : nb + 2);
        exp_rd = '0;
        if (!err && !we)
            for (int k = 0; k < nb; k++) exp_rd[k*32 +: 32] = model_get(rg*65536 + int'(off) + k);
        check({tag, "/req_ready"}, req_ready, 1);
        req_valid = 1; req_we = we; req_vec = vec; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        cyc = 0;
        seen = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                req_valid = 0; req_we = 1'($urandom); req_vec = 1'($urandom);
                req_addr = $urandom;
                req_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end
            if (mem_sel != 3'b000) begin
                if (!err && seen < nb) begin
                    check({tag, "/sel"}, mem_sel, 3'b001 << rg);
                    check({tag, "/we"}, mem_we, we);
                    check({tag, "/addr"}, mem_addr, 32'(off + seen));
                    if (we) check({tag, "/wdata"}, mem_wdata, wd[seen*32 +: 32]);
                end
                seen++;
            end
        end while (!resp_valid && cyc < 50);
        check({tag, "/latency"}, cyc, lat);
        check({tag, "/beats"}, seen, err ? 0 : nb);
        check({tag, "/err"}, resp_err, err);
        check({tag, "/rdata"}, resp_rdata, exp_rd);
        for (int s = 0; s < stall; s++) begin
            req_valid = 1; req_we = 0; req_vec = 0; req_addr = 32'd1005;
            @(negedge clk);
            check({tag, "/stall_valid"}, resp_valid, 1);
            check({tag, "/stall_rdata"}, resp_rdata, exp_rd);
            check({tag, "/stall_err"}, resp_err, err);
            check({tag, "/stall_ready"}, req_ready, 0);
            check({tag, "/stall_sel"}, mem_sel, 0);
        end
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        req_valid = 0;
        check({tag, "/hs_valid"}, resp_valid, 0);
        check({tag, "/hs_ready"}, req_ready, 1);
        if (!err && we)
            for (int k = 0; k < nb; k++) model_mem[rg*65536 + int'(off) + k] = wd[k*32 +: 32];
    endtask

    initial begin
        logic [191:0] wd;
        int r;
        logic [31:0] a;
        dev_mem[65536 + 5] = 32'hA5A5A5A5;
        model_mem[65536 + 5] = 32'hA5A5A5A5;

        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("rst/req_ready", req_ready, 1);
        check("rst/resp_valid", resp_valid, 0);
        check("rst/resp_err", resp_err, 0);
        check("rst/resp_rdata", resp_rdata, 0);
        check("rst/mem_sel", mem_sel, 0);
        check("rst/mem_we", mem_we, 0);
        check("rst/mem_addr", mem_addr, 0);
        check("rst/mem_wdata", mem_wdata, 0);

        do_txn(0, 0, 32'd1005, '0, 0, "scalar_rd");
        wd = '0;
        for (int k = 0; k < 6; k++) wd[k*32 +: 32] = 32'(k + 1);
        do_txn(1, 1, 32'd31010, wd, 0, "vec_wr");
        do_txn(0, 1, 32'd31010, '0, 1, "vec_rd_back");
        do_txn(0, 1, 32'd30997, '0, 0, "span_err");
        do_txn(1, 0, 32'd500, 32'hDEAD, 0, "ro_wr");
        do_txn(0, 0, 32'd61015, '0, 0, "nohit");
        do_txn(0, 1, 32'hFFFF_FFFD, '0, 0, "wrap");
        do_txn(0, 1, 32'd1000, '0, 10, "stall");
        do_txn(0, 0, 32'd1005, '0, 0, "queued");
        do_txn(0, 0, 32'd999, '0, 0, "r0_last");
        do_txn(0, 1, 32'd994, '0, 0, "r0_vec_fit");
        do_txn(0, 1, 32'd995, '0, 0, "r0_vec_over");
        do_txn(1, 1, 32'd61009, {6{$urandom}}, 0, "r2_vec_fit");
        do_txn(1, 1, 32'd61010, {6{$urandom}}, 0, "r2_vec_over");
        do_txn(1, 0, 32'd2000, 32'h1234, 0, "rom_wr");

        // Reset while beat 3 of a vector write is on the bus
        wd = '0;
        for (int k = 0; k < 6; k++) wd[k*32 +: 32] = 32'h70 + 32'(k);
        req_valid = 1; req_we = 1; req_vec = 1; req_addr = 32'd31010; req_wdata = wd;
        @(posedge clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = 0;
        end
        check("rstmid/beat3_addr", mem_addr, 32'd13);
        rst = 0;
        #1;
        check("rstmid/mem_we", mem_we, 0);
        check("rstmid/mem_sel", mem_sel, 0);
        check("rstmid/resp_valid", resp_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("rstmid/req_ready", req_ready, 1);
        check("rstmid/no_resp", resp_valid, 0);
        for (int k = 0; k < 3; k++) model_mem[2*65536 + 10 + k] = wd[k*32 +: 32];
        do_txn(0, 1, 32'd31010, '0, 0, "after_rst");
        do_txn(0, 0, 32'd1005, '0, 0, "after_rst_scalar");

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 3);
            if (r < 3) a = 32'(base_tab[r] + longint'($urandom_range(0, 32'(size_tab[r]) + 6)) - 6);
            else a = $urandom;
            do_txn(1'($urandom), 1'($urandom), a,
                   {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                   $urandom_range(0, 2), $sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_map_ctrl.md
Name: mem_map_ctrl

Overview:
- Parametrised, handshaked successor to the current combinational address-map memory controller.
- Decodes a CPU data request against NUM_REGIONS configurable address windows and applies per-region write protection.
- Splits V-bit vector accesses into LANES = V/S sequential S-bit beats on a shared word-wide backing-memory port.
- Returns read data and an error flag through a valid/ready response channel; sits between the core's memory stage and the imem/ROM/RAM arrays.

Parameters:
- S, 32, scalar word width and address width
- V, 192, vector width; must be a multiple of S (elaboration assertion); LANES = V/S
- NUM_REGIONS, 3, number of address windows
- REGION_BASE, {31000,1000,0}, packed NUM_REGIONS*S bases; index 0 is least significant
- REGION_SIZE, {30015,30000,1000}, packed NUM_REGIONS*S sizes in words
- REGION_WRITABLE, 3'b100, per-region write enable mask

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_we  in  1  1 = write, 0 = read
- req_vec  in  1  1 = vector (LANES beats), 0 = scalar (1 beat)
- req_addr  in  S  word address
- req_wdata  in  V  write data; lane k at [k*S +: S]; scalar uses lane 0
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed
- resp_rdata  out  V  read data; scalar reads zero-extend lane 0
- resp_err  out  1  decode, protection or wrap error
- mem_sel  out  NUM_REGIONS  one-hot region select
- mem_we  out  1  beat write strobe
- mem_addr  out  S  region-relative word address
- mem_wdata  out  S  beat write data
- mem_rdata  in  NUM_REGIONS*S  per-region read data, one-cycle synchronous latency

Behaviour:
- Reset (async, rst=0):
  - State goes to IDLE.
  - resp_valid, resp_err, resp_rdata, mem_sel, mem_we, mem_addr, mem_wdata all go to 0.
  - req_ready is 1 immediately after reset is released.
  - Reset mid-operation aborts the transaction: no partial response is produced, and mem_sel/mem_we drop asynchronously.
- States: IDLE, ISSUE, DRAIN, RESP. req_ready = (state==IDLE); no request is accepted in any other state.
- Decode (on acceptance, combinational on request inputs):
  - nbeats = req_vec ? LANES : 1.
  - last = req_addr + nbeats - 1, computed at S+1 bits.
  - Region i hits when REGION_BASE_i <= req_addr and last < REGION_BASE_i + REGION_SIZE_i, i.e. the whole access lies inside the region.
  - Lowest hitting index wins on overlap.
  - Error when there is no hit, last overflows 2^S, or req_we=1 to a region without its REGION_WRITABLE bit.
- IDLE, on acceptance:
  - Error: go to RESP with resp_err=1 and resp_rdata=0; no mem_* activity.
  - Otherwise latch the request, region index, offset and nbeats into registers, then go to ISSUE with beat counter = 0.
- ISSUE (one beat per cycle):
  - mem_sel = onehot(region), mem_addr = offset + k, mem_we = latched we, mem_wdata = lane k.
  - Write: after beat nbeats-1, go to RESP.
  - Read: capture the selected mem_rdata slice into lane k-1 in the cycle after beat k is issued; after the last beat go to DRAIN.
  - mem_sel/mem_we are 0 outside ISSUE.
- DRAIN: capture the last lane, then go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err stay stable until resp_ready=1.
  - On handshake, clear resp_valid and return to IDLE.
  - resp_ready held low stalls indefinitely with no memory activity.
- Latency, measured from the acceptance edge to the first cycle resp_valid=1:
  - Error: 1 cycle.
  - Write: nbeats+1 cycles.
  - Read: nbeats+2 cycles.
  - Back-to-back: the earliest next acceptance is the cycle after the response handshake.
- Write data and the address are sampled only at acceptance; later changes on req_* are ignored.

Decomposition:
- Package mem_map_pkg holds:
  - state_t enum (IDLE/ISSUE/DRAIN/RESP).
  - Default region base/size/writable constants for INS/ROM/RAM (0/1000, 1000/30000, 31000/30015).
  - A localparam helper computing LANES.
- One combinational sub-module, mem_region_decode, takes addr, nbeats and we and returns hit, region index, offset and err. The FSM and datapath stay in mem_map_ctrl.

Test Plan:
- Scalar read at addr 1005, region1 returns 0xA5A5A5A5 -> one beat with mem_sel=3'b010, mem_addr=5; resp_valid 3 cycles after accept; resp_rdata={160'b0,32'hA5A5A5A5}; resp_err=0.
- Vector write at addr 31010, lanes 0..5 = 1..6 -> six consecutive beats to mem_addr 10..15 carrying data 1..6 with mem_we=1; resp 7 cycles after accept; err=0.
- Vector read at addr 30997, spanning region1/region2 -> resp_err=1 one cycle after accept; resp_rdata=0; mem_sel never asserted.
- Write at addr 500 (region0, read-only) -> resp_err=1 with no mem_we pulse. Read at addr 61015 -> resp_err=1. Vector at addr 2^32-3 -> wrap error.
- Vector read at addr 1000 with resp_ready held low 10 cycles -> resp_valid and rdata stable; req_ready=0 throughout; handshake returns to IDLE, and a queued request is accepted on the next cycle.
- Assert rst=0 during beat 3 of a vector write -> mem_we drops immediately with no response; after release req_ready=1 and a new scalar read completes normally.
